// File: rtl/andor_apb_timer_slave.sv
// APB3 responder on the MSS fabric-master port: down-counting timer (one-shot or
// auto-reload), scratch register and read-only ID register, with a level interrupt.
//
// Ports:
//   FAB_CLK      fabric clock, all state on the rising edge
//   M2FRESETn    asynchronous active-low reset
//   MSSPADDR     APB address, bits [4:0] decoded
//   MSSPSEL      APB select
//   MSSPENABLE   APB enable (access phase)
//   MSSPWRITE    1 = write, 0 = read
//   MSSPWDATA    APB write data
//   MSSPRDATA    APB read data, combinational during the access phase
//   MSSPREADY    APB ready after WAIT_STATES extra access cycles
//   MSSPSLVERR   APB slave error, completion cycle only
//   FABINT       registered STATUS.IRQ & CTRL.IE
//
// Register map: 0x00 CTRL {AR,IE,EN}, 0x04 LOAD, 0x08 VALUE (RO),
//               0x0C STATUS bit0 IRQ (W1C), 0x10 SCRATCH, 0x14 ID (RO).
module andor_apb_timer_slave #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA0D0_0001
) (
  input  logic        FAB_CLK,
  input  logic        M2FRESETn,
  input  logic [31:0] MSSPADDR,
  input  logic        MSSPSEL,
  input  logic        MSSPENABLE,
  input  logic        MSSPWRITE,
  input  logic [31:0] MSSPWDATA,
  output logic [31:0] MSSPRDATA,
  output logic        MSSPREADY,
  output logic        MSSPSLVERR,
  output logic        FABINT
);

  localparam logic [2:0] WaitLimit  = WAIT_STATES[2:0];
  localparam logic [2:0] IdxCtrl    = 3'd0;
  localparam logic [2:0] IdxLoad    = 3'd1;
  localparam logic [2:0] IdxValue   = 3'd2;
  localparam logic [2:0] IdxStatus  = 3'd3;
  localparam logic [2:0] IdxScratch = 3'd4;
  localparam logic [2:0] IdxId      = 3'd5;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] value_q, value_d;
  logic        irq_q, irq_d;
  logic [31:0] scratch_q, scratch_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        fabint_q;

  logic       access;
  logic       ready;
  logic       bad_addr;
  logic       err;
  logic       wr_en;
  logic       irq_set;
  logic [2:0] idx;
  logic       unused_addr;

  assign unused_addr = ^MSSPADDR[31:5];

  // Reset gating keeps READY and RDATA low combinationally while reset is held.
  assign access   = MSSPSEL & MSSPENABLE & M2FRESETn;
  assign ready    = access & (wcnt_q == WaitLimit);
  assign idx      = MSSPADDR[4:2];
  assign bad_addr = (MSSPADDR[1:0] != 2'b00) | (idx > IdxId);
  assign err      = bad_addr | (MSSPWRITE & ((idx == IdxValue) | (idx == IdxId)));
  assign wr_en    = ready & MSSPWRITE & ~err;
  assign wcnt_d   = (access & ~ready) ? wcnt_q + 3'd1 : 3'd0;

  assign MSSPREADY  = ready;
  assign MSSPSLVERR = ready & err;
  assign FABINT     = fabint_q;

  always_comb begin
    MSSPRDATA = 32'd0;
    if (access & ~err) begin
      case (idx)
        IdxCtrl:    MSSPRDATA = {29'd0, ctrl_q};
        IdxLoad:    MSSPRDATA = load_q;
        IdxValue:   MSSPRDATA = value_q;
        IdxStatus:  MSSPRDATA = {31'd0, irq_q};
        IdxScratch: MSSPRDATA = scratch_q;
        IdxId:      MSSPRDATA = ID_VALUE;
        default:    MSSPRDATA = 32'd0;
      endcase
    end
  end

  // Timer first, APB write second so a write overrides the timer's update;
  // the IRQ set is applied last so it beats a same-cycle W1C.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    value_d   = value_q;
    irq_d     = irq_q;
    scratch_d = scratch_q;
    irq_set   = 1'b0;

    if (ctrl_q[0]) begin
      if (value_q != 32'd0) begin
        value_d = value_q - 32'd1;
      end else begin
        irq_set = 1'b1;
        if (ctrl_q[2]) begin
          value_d = load_q;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end
    end

    if (wr_en) begin
      case (idx)
        IdxCtrl:    ctrl_d = MSSPWDATA[2:0];
        IdxLoad: begin
          load_d  = MSSPWDATA;
          value_d = MSSPWDATA;
        end
        IdxStatus:  if (MSSPWDATA[0]) irq_d = 1'b0;
        IdxScratch: scratch_d = MSSPWDATA;
        default:    ;
      endcase
    end

    if (irq_set) irq_d = 1'b1;
  end

  always_ff @(posedge FAB_CLK or negedge M2FRESETn) begin
    if (!M2FRESETn) begin
      ctrl_q    <= 3'd0;
      load_q    <= 32'd0;
      value_q   <= 32'd0;
      irq_q     <= 1'b0;
      scratch_q <= 32'd0;
      wcnt_q    <= 3'd0;
      fabint_q  <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      irq_q     <= irq_d;
      scratch_q <= scratch_d;
      wcnt_q    <= wcnt_d;
      fabint_q  <= irq_q & ctrl_q[1];
    end
  end

endmodule

// File: tb/tb_andor_apb_timer_slave.sv
module tb_andor_apb_timer_slave;

  localparam int NDut = 3;
  localparam logic [31:0] IdVal = 32'hA0D0_0001;

  logic clk;
  logic rst_n;
  int   cyc;

  logic [31:0] paddr   [NDut];
  logic [31:0] pwdata  [NDut];
  logic        psel    [NDut];
  logic        penable [NDut];
  logic        pwrite  [NDut];
  logic [31:0] prdata  [NDut];
  logic        pready  [NDut];
  logic        pslverr [NDut];
  logic        fabint  [NDut];

  int n_tests = 0;
  int n_fail  = 0;
  logic last_fint;

  // Reference model of the architectural registers per instance.
  logic [2:0]  m_ctrl    [NDut];
  logic [31:0] m_load    [NDut];
  logic [31:0] m_value   [NDut];
  logic [31:0] m_scratch [NDut];
  logic        m_irq     [NDut];
  int          clears[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  andor_apb_timer_slave #(.WAIT_STATES(0)) u_dut0 (
    .FAB_CLK(clk), .M2FRESETn(rst_n), .MSSPADDR(paddr[0]), .MSSPSEL(psel[0]),
    .MSSPENABLE(penable[0]), .MSSPWRITE(pwrite[0]), .MSSPWDATA(pwdata[0]),
    .MSSPRDATA(prdata[0]), .MSSPREADY(pready[0]), .MSSPSLVERR(pslverr[0]), .FABINT(fabint[0])
  );
  andor_apb_timer_slave #(.WAIT_STATES(3)) u_dut1 (
    .FAB_CLK(clk), .M2FRESETn(rst_n), .MSSPADDR(paddr[1]), .MSSPSEL(psel[1]),
    .MSSPENABLE(penable[1]), .MSSPWRITE(pwrite[1]), .MSSPWDATA(pwdata[1]),
    .MSSPRDATA(prdata[1]), .MSSPREADY(pready[1]), .MSSPSLVERR(pslverr[1]), .FABINT(fabint[1])
  );
  andor_apb_timer_slave #(.WAIT_STATES(2)) u_dut2 (
    .FAB_CLK(clk), .M2FRESETn(rst_n), .MSSPADDR(paddr[2]), .MSSPSEL(psel[2]),
    .MSSPENABLE(penable[2]), .MSSPWRITE(pwrite[2]), .MSSPWDATA(pwdata[2]),
    .MSSPRDATA(prdata[2]), .MSSPREADY(pready[2]), .MSSPSLVERR(pslverr[2]), .FABINT(fabint[2])
  );

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] exp_reg(input int d, input logic [2:0] idx);
    case (idx)
      3'd0:    return {29'd0, m_ctrl[d]};
      3'd1:    return m_load[d];
      3'd2:    return m_value[d];
      3'd3:    return {31'd0, m_irq[d]};
      3'd4:    return m_scratch[d];
      default: return IdVal;
    endcase
  endfunction

  // Auto-reload IRQ at k edges after enable: set on every positive multiple of p,
  // cleared by a W1C at edge w unless a set lands on that same edge.
  function automatic bit ar_irq(input int k, input int p);
    int s;
    int wl;
    s  = (k / p) * p;
    wl = -1;
    foreach (clears[i]) if (clears[i] <= k && clears[i] > wl) wl = clears[i];
    return (s > 0) && (s >= wl);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the commit edge.
  task automatic apb(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int obs,
                     output int commit);
    int n;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
    #1;
    check($sformatf("d%0d_setup_ready", d), {31'd0, pready[d]}, 32'd0);
    check($sformatf("d%0d_setup_rdata", d), prdata[d], 32'd0);
    @(negedge clk);
    penable[d] = 1'b1;
    n = 1;
    #1;
    while (pready[d] !== 1'b1 && n <= 16) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("d%0d_access_cycles", d), 32'(n), 32'(ws_of(d) + 1));
    rdata     = prdata[d];
    err       = pslverr[d];
    last_fint = fabint[d];
    obs       = cyc;
    @(posedge clk);
    #1;
    commit = cyc;
    @(negedge clk);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [31:0] addr, input logic [31:0] data,
                    output logic err, output int commit);
    logic [31:0] dummy;
    int obs;
    apb(d, 1'b1, addr, data, dummy, err, obs, commit);
  endtask

  task automatic wr_ok(input int d, input logic [31:0] addr, input logic [31:0] data,
                       output int commit);
    logic e;
    wr(d, addr, data, e, commit);
    check($sformatf("d%0d_wr_err_%h", d, addr), {31'd0, e}, 32'd0);
  endtask

  task automatic rd(input int d, input logic [31:0] addr, output logic [31:0] data,
                    output logic err, output int obs);
    int commit;
    apb(d, 1'b0, addr, 32'd0, data, err, obs, commit);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < NDut; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
      m_ctrl[d] = '0; m_load[d] = '0; m_value[d] = '0; m_scratch[d] = '0; m_irq[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < NDut; d++) begin
      check($sformatf("d%0d_rst_ready", d), {31'd0, pready[d]}, 32'd0);
      check($sformatf("d%0d_rst_slverr", d), {31'd0, pslverr[d]}, 32'd0);
      check($sformatf("d%0d_rst_rdata", d), prdata[d], 32'd0);
      check($sformatf("d%0d_rst_fabint", d), {31'd0, fabint[d]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_all(input int d);
    logic [31:0] v;
    logic e;
    int obs;
    for (int i = 0; i < 6; i++) begin
      rd(d, 32'(i * 4), v, e, obs);
      check($sformatf("d%0d_reg%0d", d, i), v, exp_reg(d, 3'(i)));
      check($sformatf("d%0d_reg%0d_err", d, i), {31'd0, e}, 32'd0);
    end
  endtask

  task automatic rand_regs(input int d, input int n);
    logic [31:0] r, hi, v;
    logic [2:0]  idx;
    logic        e;
    int          obs, cm;
    for (int i = 0; i < n; i++) begin
      r  = $urandom;
      hi = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0: begin
            r[0] = 1'b0;
            wr_ok(d, {hi[31:5], 5'h00}, r, cm);
            m_ctrl[d] = r[2:0];
          end
          1: begin
            wr_ok(d, {hi[31:5], 5'h04}, r, cm);
            m_load[d]  = r;
            m_value[d] = r;
          end
          default: begin
            wr_ok(d, {hi[31:5], 5'h10}, r, cm);
            m_scratch[d] = r;
          end
        endcase
      end else begin
        idx = 3'($urandom_range(0, 5));
        rd(d, {hi[31:5], idx, 2'b00}, v, e, obs);
        check($sformatf("d%0d_rand_rd%0d", d, idx), v, exp_reg(d, idx));
        check($sformatf("d%0d_rand_rd_err", d), {31'd0, e}, 32'd0);
      end
    end
  endtask

  task automatic err_cases(input int d);
    logic [31:0] v, r;
    logic        e;
    int          obs, cm;
    r = $urandom;
    wr(d, 32'h08, r, e, cm);
    check($sformatf("d%0d_wr_value_err", d), {31'd0, e}, 32'd1);
    rd(d, 32'h08, v, e, obs);
    check($sformatf("d%0d_value_kept", d), v, m_value[d]);
    wr(d, 32'h14, r, e, cm);
    check($sformatf("d%0d_wr_id_err", d), {31'd0, e}, 32'd1);
    rd(d, 32'h14, v, e, obs);
    check($sformatf("d%0d_id_kept", d), v, IdVal);
    rd(d, ($urandom_range(0, 1) == 1) ? 32'h18 : 32'h1C, v, e, obs);
    check($sformatf("d%0d_oob_err", d), {31'd0, e}, 32'd1);
    check($sformatf("d%0d_oob_rdata", d), v, 32'd0);
    rd(d, 32'h02, v, e, obs);
    check($sformatf("d%0d_mis02_err", d), {31'd0, e}, 32'd1);
    check($sformatf("d%0d_mis02_rdata", d), v, 32'd0);
    wr(d, 32'h10 | 32'($urandom_range(1, 3)), r, e, cm);
    check($sformatf("d%0d_mis_wr_err", d), {31'd0, e}, 32'd1);
    rd(d, 32'h10, v, e, obs);
    check($sformatf("d%0d_scratch_kept", d), v, m_scratch[d]);
  endtask

  task automatic timer_prep(input int d, input int l, input logic [2:0] mode, output int c0);
    int cm;
    wr_ok(d, 32'h00, 32'h0, cm);
    wr_ok(d, 32'h0C, 32'h1, cm);
    wr_ok(d, 32'h04, 32'(l), cm);
    wr_ok(d, 32'h00, {29'd0, mode}, c0);
  endtask

  task automatic one_shot(input int d, input int l);
    int c0, k, obs, g;
    logic [31:0] v;
    logic e;
    bit done;
    timer_prep(d, l, 3'b011, c0);
    done = 1'b0;
    g    = 0;
    fork
      begin
        while (cyc - c0 < l + 5) begin
          idle($urandom_range(0, 2));
          case ($urandom_range(0, 2))
            0: begin
              rd(d, 32'h08, v, e, obs);
              k = obs - c0;
              check($sformatf("d%0d_os_value_k%0d", d, k), v, 32'((k <= l) ? l - k : 0));
            end
            1: begin
              rd(d, 32'h0C, v, e, obs);
              k = obs - c0;
              check($sformatf("d%0d_os_irq_k%0d", d, k), v, {31'd0, k >= l + 1});
            end
            default: begin
              rd(d, 32'h00, v, e, obs);
              k = obs - c0;
              check($sformatf("d%0d_os_ctrl_k%0d", d, k), v, {29'd0, 2'b01, k <= l});
            end
          endcase
        end
        done = 1'b1;
      end
      begin
        while (!done && g < 200) begin
          @(negedge clk);
          g++;
          check($sformatf("d%0d_os_fabint_k%0d", d, cyc - c0), {31'd0, fabint[d]},
                {31'd0, (cyc - c0) >= l + 2});
        end
      end
    join
    m_ctrl[d] = 3'b010; m_load[d] = 32'(l); m_value[d] = 32'd0; m_irq[d] = 1'b1;
  endtask

  // A CTRL write landing on the one-shot auto-clear edge must take effect.
  task automatic ctrl_race(input int d);
    int c0, cm, l, obs;
    logic [31:0] v;
    logic e;
    l = ws_of(d) + 2 + $urandom_range(0, 3);
    timer_prep(d, l, 3'b011, c0);
    idle((c0 + l + 1) - (cyc + 2 + ws_of(d)));
    wr_ok(d, 32'h00, 32'h1, cm);
    check($sformatf("d%0d_race_commit", d), 32'(cm - c0), 32'(l + 1));
    rd(d, 32'h00, v, e, obs);
    check($sformatf("d%0d_race_ctrl", d), v, 32'd0);
    rd(d, 32'h0C, v, e, obs);
    check($sformatf("d%0d_race_irq", d), v, 32'd1);
    m_ctrl[d] = 3'b000; m_load[d] = 32'(l); m_value[d] = 32'd0; m_irq[d] = 1'b1;
  endtask

  task automatic auto_reload(input int d, input int l, input int iters);
    int c0, k, obs, cm, p, nxt, t, g;
    logic [31:0] v;
    logic e;
    bit done;
    p = l + 1;
    clears.delete();
    timer_prep(d, l, 3'b111, c0);
    done = 1'b0;
    g    = 0;
    fork
      begin
        for (int i = 0; i < iters; i++) begin
          idle($urandom_range(0, 3));
          case ($urandom_range(0, 2))
            0: begin
              rd(d, 32'h08, v, e, obs);
              k = obs - c0;
              check($sformatf("d%0d_ar_value_k%0d", d, k), v, 32'(l - (k % p)));
            end
            1: begin
              rd(d, 32'h0C, v, e, obs);
              k = obs - c0;
              check($sformatf("d%0d_ar_irq_k%0d", d, k), v, {31'd0, ar_irq(k, p)});
            end
            default: begin
              nxt = cyc + 2 + ws_of(d) - c0;
              if ($urandom_range(0, 1) == 1) begin
                t = ((nxt + p - 1) / p) * p;
                idle(t - nxt);
              end
              wr_ok(d, 32'h0C, 32'h1, cm);
              clears.push_back(cm - c0);
            end
          endcase
        end
        done = 1'b1;
      end
      begin
        while (!done && g < 400) begin
          @(negedge clk);
          g++;
          check($sformatf("d%0d_ar_fabint_k%0d", d, cyc - c0), {31'd0, fabint[d]},
                {31'd0, ar_irq(cyc - c0 - 1, p)});
        end
      end
    join
    wr_ok(d, 32'h00, 32'h0, cm);
    m_value[d] = 32'(l - ((cm - c0) % p));
    wr_ok(d, 32'h0C, 32'h1, cm);
    m_ctrl[d] = 3'b000; m_load[d] = 32'(l); m_irq[d] = 1'b0;
    rd(d, 32'h08, v, e, obs);
    check($sformatf("d%0d_ar_frozen", d), v, m_value[d]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, r;
    logic        e;
    int          obs, cm;

    do_reset();

    rd(0, 32'h14, v, e, obs);
    check("id_ws0", v, IdVal);
    check("id_ws0_err", {31'd0, e}, 32'd0);

    wr(1, 32'h10, 32'hDEAD_BEEF, e, cm);
    check("scratch_ws3_wr_err", {31'd0, e}, 32'd0);
    m_scratch[1] = 32'hDEAD_BEEF;
    rd(1, 32'h10, v, e, obs);
    check("scratch_ws3_rd", v, 32'hDEAD_BEEF);

    for (int d = 0; d < NDut; d++) begin
      read_all(d);
      rand_regs(d, 12);
      err_cases(d);
    end

    one_shot(0, 5);
    one_shot(1, $urandom_range(1, 6));
    ctrl_race(0);
    ctrl_race(1);
    auto_reload(0, 2, 20);
    auto_reload(1, $urandom_range(0, 4), 15);
    auto_reload(0, 0, 8);
    read_all(0);

    // Reset asserted at the point where a WAIT_STATES=2 write would complete.
    r = $urandom | 32'h1;
    wr_ok(2, 32'h10, r, cm);
    wr_ok(2, 32'h04, 32'h0, cm);
    wr_ok(2, 32'h00, 32'h3, cm);
    idle(2);
    check("rst_pre_fabint", {31'd0, fabint[2]}, 32'd1);
    psel[2] = 1'b1; pwrite[2] = 1'b1; paddr[2] = 32'h10; pwdata[2] = ~r;
    @(negedge clk);
    penable[2] = 1'b1;
    idle(2);
    #1;
    check("rst_pre_ready", {31'd0, pready[2]}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, pready[2]}, 32'd0);
    check("rst_mid_fabint", {31'd0, fabint[2]}, 32'd0);
    check("rst_mid_rdata", prdata[2], 32'd0);
    @(negedge clk);
    psel[2] = 1'b0; penable[2] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDut; d++) begin
      m_ctrl[d] = '0; m_load[d] = '0; m_value[d] = '0; m_scratch[d] = '0; m_irq[d] = 1'b0;
    end
    read_all(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
